fc_mac_engine: RTL

Parametrised fully-connected layer engine for the LeNet-5 classifier stage. It streams LANES input/weight pairs per beat and accumulates IN_LEN products plus a bias per output neuron. It emits NUM_OUT neuron results per job over a valid/ready handshake, with an optional ReLU applied per job. It replaces the fixed two-lane, fixed-length FC accumulator in the dense-layer datapath and also provides backpressure, multi-neuron sequencing and a job-done indication.

---
 rtl/fc_mac_engine.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fc_mac_engine.sv
// Fully-connected layer engine: streams LANES input/weight pairs per beat,
// accumulates IN_LEN products plus bias per neuron, emits NUM_OUT results per job.
module fc_mac_engine #(
    parameter int BIT_WIDTH = 8,
    parameter int OUT_WIDTH = 32,
    parameter int LANES     = 2,
    parameter int IN_LEN    = 72,
    parameter int NUM_OUT   = 10,
    localparam int IDX_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       relu,
    input  logic [LANES*BIT_WIDTH-1:0] in_data,
    input  logic [LANES*BIT_WIDTH-1:0] weight,
    input  logic [BIT_WIDTH-1:0]       bias,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [OUT_WIDTH-1:0]       out_value,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done
);

    localparam int BEATS  = IN_LEN / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W = 2 * BIT_WIDTH;
    localparam int EXT_W  = (PROD_W > OUT_WIDTH) ? PROD_W : OUT_WIDTH;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_OUTPUT
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]     neuron_idx_q, neuron_idx_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic                 relu_q, relu_d;
    logic [OUT_WIDTH-1:0] out_value_q, out_value_d;
    logic [IDX_W-1:0]     out_idx_q, out_idx_d;
    logic                 done_q, done_d;

    logic signed [PROD_W-1:0] prod     [LANES];
    logic signed [EXT_W-1:0]  prod_ext [LANES];
    logic signed [EXT_W-1:0]  bias_ext;
    logic [OUT_WIDTH-1:0]     lane_sum;
    logic [OUT_WIDTH-1:0]     sum;

    // Products are extended to the wider of product/accumulator width, then
    // truncated to OUT_WIDTH so every addition wraps modulo 2^OUT_WIDTH.
    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            prod[k]     = $signed(in_data[k*BIT_WIDTH +: BIT_WIDTH])
                        * $signed(weight[k*BIT_WIDTH +: BIT_WIDTH]);
            prod_ext[k] = EXT_W'(prod[k]);
            lane_sum    = lane_sum + prod_ext[k][OUT_WIDTH-1:0];
        end
        bias_ext = EXT_W'($signed(bias));
        sum      = ((beat_cnt_q == '0) ? bias_ext[OUT_WIDTH-1:0] : acc_q) + lane_sum;
    end

    // Handshake: a beat transfers on a cycle where in_valid && in_ready, a result
    // on a cycle where out_valid && out_ready; out_value/out_idx hold while unaccepted.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        neuron_idx_d = neuron_idx_q;
        acc_d        = acc_q;
        relu_d       = relu_q;
        out_value_d  = out_value_q;
        out_idx_d    = out_idx_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    relu_d       = relu;
                    beat_cnt_d   = '0;
                    neuron_idx_d = '0;
                    acc_d        = '0;
                    state_d      = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_d = sum;
                    if (beat_cnt_q == LAST_BEAT) begin
                        out_value_d = (relu_q && sum[OUT_WIDTH-1]) ? '0 : sum;
                        out_idx_d   = neuron_idx_q;
                        beat_cnt_d  = '0;
                        state_d     = S_OUTPUT;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    if (neuron_idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        neuron_idx_d = neuron_idx_q + 1'b1;
                        state_d      = S_ACCUM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            neuron_idx_q <= '0;
            acc_q        <= '0;
            relu_q       <= 1'b0;
            out_value_q  <= '0;
            out_idx_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            neuron_idx_q <= neuron_idx_d;
            acc_q        <= acc_d;
            relu_q       <= relu_d;
            out_value_q  <= out_value_d;
            out_idx_q    <= out_idx_d;
            done_q       <= done_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_OUTPUT);
    assign busy      = (state_q != S_IDLE);
    assign out_value = out_value_q;
    assign out_idx   = out_idx_q;
    assign done      = done_q;

endmodule
